// File: rtl/ocimem_debug_arbiter.sv
// Monitor RAM arbiter: shares a single-port, 1-cycle-latency debug RAM between
// the JTAG ocimem command strobes and an Avalon-MM slave port. Each access is
// sequenced IDLE -> ISSUE [-> CAPTURE] -> IDLE with round-robin arbitration.
module ocimem_debug_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_jtag_addr;
  logic                r_jtag_pend;
  logic                r_jtag_dir;
  logic [DATA_W-1:0]   r_jtag_wdata;
  logic [DATA_W-1:0]   r_mon;
  logic                r_overrun;
  logic [DATA_W-1:0]   r_avs_rdata;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_own_jtag;   // owner of the op in flight
  logic                r_op_wr;      // op in flight is a write
  logic                r_last_jtag;  // last grant went to JTAG

  logic                w_avs_req;
  logic                w_jtag_inflight;
  logic                w_grant_jtag;
  logic                w_grant_any;
  logic                w_jtag_done;
  logic                w_avs_cap;
  logic [ADDR_W-1:0]   w_jdo_addr;
  logic                w_unused;

  assign w_avs_req       = avs_read | avs_write;
  assign w_jtag_inflight = (r_state != S_IDLE) && r_own_jtag;
  // JTAG wins when alone, or on a tie when Avalon was granted last
  assign w_grant_jtag    = r_jtag_pend && (!w_avs_req || !r_last_jtag);
  assign w_grant_any     = r_jtag_pend || w_avs_req;
  assign w_jtag_done     = r_own_jtag &&
                           ((r_state == S_ISSUE && r_op_wr) || r_state == S_CAPTURE);
  assign w_avs_cap       = (r_state == S_CAPTURE) && !r_own_jtag && !reset;
  assign w_jdo_addr      = jdo[ADDR_W+16:17];
  assign w_unused        = &{1'b0, jdo[37:36], jdo[2:0]};

  assign MonDReg         = r_mon;
  assign jtag_busy       = r_jtag_pend | w_jtag_inflight;
  assign jtag_overrun    = r_overrun;
  assign ram_addr        = r_ram_addr;
  assign ram_wdata       = r_ram_wdata;
  // Reset kills a write strobe in the very cycle it is asserted
  assign ram_wr          = r_ram_wr & ~reset;
  // Read data is forwarded straight from the RAM in the completion cycle
  assign avs_readdata    = w_avs_cap ? ram_rdata : r_avs_rdata;
  assign avs_waitrequest = reset ||
                           !((r_state == S_ISSUE && !r_own_jtag && r_op_wr) ||
                             (r_state == S_CAPTURE && !r_own_jtag));

  // JTAG command capture, address pointer and access sequencing FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_jtag_addr  <= '0;
      r_jtag_pend  <= 1'b0;
      r_jtag_dir   <= 1'b0;
      r_jtag_wdata <= '0;
      r_mon        <= '0;
      r_overrun    <= 1'b0;
      r_avs_rdata  <= '0;
      r_ram_addr   <= '0;
      r_ram_wr     <= 1'b0;
      r_ram_wdata  <= '0;
      r_own_jtag   <= 1'b0;
      r_op_wr      <= 1'b0;
      r_last_jtag  <= 1'b0;
    end else begin
      if (take_action_ocimem_b) begin
        if (!r_jtag_pend && !w_jtag_inflight) begin
          r_jtag_pend  <= 1'b1;
          r_jtag_dir   <= jdo[35];
          r_jtag_wdata <= jdo[34:3];
        end else begin
          r_overrun <= 1'b1;
        end
      end

      // An explicit address load overrides the post-access increment
      if (take_action_ocimem_a)
        r_jtag_addr <= w_jdo_addr;
      else if (w_jtag_done)
        r_jtag_addr <= r_jtag_addr + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_state     <= S_ISSUE;
            r_own_jtag  <= w_grant_jtag;
            r_last_jtag <= w_grant_jtag;
            if (w_grant_jtag) begin
              r_ram_addr  <= r_jtag_addr;
              r_ram_wdata <= r_jtag_wdata;
              r_ram_wr    <= r_jtag_dir;
              r_op_wr     <= r_jtag_dir;
              r_jtag_pend <= 1'b0;
            end else begin
              r_ram_addr  <= avs_address;
              r_ram_wdata <= avs_writedata;
              r_ram_wr    <= avs_write;
              r_op_wr     <= avs_write;
            end
          end
        end
        S_ISSUE: begin
          r_ram_wr <= 1'b0;
          if (r_op_wr) begin
            r_state <= S_IDLE;
            if (r_own_jtag) r_mon <= r_ram_wdata;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
          if (r_own_jtag) r_mon       <= ram_rdata;
          else            r_avs_rdata <= ram_rdata;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocimem_debug_arbiter.sv
// Directed bench for ocimem_debug_arbiter with a behavioural 1-cycle RAM.
module tb_ocimem_debug_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:255];
  int errors = 0;
  int checks = 0;
  logic [7:0] ia;
  logic       iw;

  ocimem_debug_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] ja(input logic [7:0] a);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] jb(input logic dir, input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[35] = dir;
    v[34:3] = d;
    return v;
  endfunction

  task automatic jtag_a(input logic [7:0] a);
    jdo = ja(a); take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
  endtask

  // Strobe one JTAG access and run it to completion; reports the ISSUE-cycle bus
  task automatic jop(input logic dir, input logic [31:0] d,
                     output logic [7:0] a, output logic w);
    jdo = jb(dir, d); take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    cyc();
    a = ram_addr; w = ram_wr;
    cyc();
    if (!dir) cyc();
  endtask

  initial begin
    reset = 1'b1; jdo = '0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    cyc(); cyc();
    chk("rst MonDReg", MonDReg, 32'h0);
    chk("rst busy", jtag_busy, 0);
    chk("rst overrun", jtag_overrun, 0);
    chk("rst readdata", avs_readdata, 32'h0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wr", ram_wr, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    chk("rst waitreq", avs_waitrequest, 1);
    reset = 1'b0;
    cyc();

    // JTAG write, write, then read back with simultaneous address load
    jtag_a(8'h10);
    jop(1'b1, 32'hDEADBEEF, ia, iw);
    chk("t1 wr0 addr", ia, 8'h10);
    chk("t1 wr0 ram_wr", iw, 1);
    chk("t1 wr0 MonDReg", MonDReg, 32'hDEADBEEF);
    jop(1'b1, 32'hCAFEF00D, ia, iw);
    chk("t1 wr1 addr", ia, 8'h11);
    chk("t1 wr1 MonDReg", MonDReg, 32'hCAFEF00D);
    chk("t1 mem10", mem[8'h10], 32'hDEADBEEF);
    jdo = ja(8'h10); take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    chk("t1 rd busy", jtag_busy, 1);
    cyc();
    chk("t1 rd addr", ram_addr, 8'h10);
    chk("t1 rd ram_wr", ram_wr, 0);
    cyc(); cyc();
    chk("t1 rd MonDReg", MonDReg, 32'hDEADBEEF);
    chk("t1 jtag_addr", dut.r_jtag_addr, 8'h11);
    chk("t1 idle busy", jtag_busy, 0);

    // Auto-increment wrap
    jtag_a(8'hFF);
    jop(1'b1, 32'h0BADF00D, ia, iw);
    chk("t2 wr addr ff", ia, 8'hFF);
    jop(1'b1, 32'h600DCAFE, ia, iw);
    chk("t2 wr addr 00", ia, 8'h00);
    jtag_a(8'hFF);
    jop(1'b0, 32'h0, ia, iw);
    chk("t2 rd addr ff", ia, 8'hFF);
    chk("t2 rd ff data", MonDReg, 32'h0BADF00D);
    jop(1'b0, 32'h0, ia, iw);
    chk("t2 rd addr 00", ia, 8'h00);
    chk("t2 rd 00 data", MonDReg, 32'h600DCAFE);
    chk("t2 jtag_addr", dut.r_jtag_addr, 8'h01);

    // Contention from reset: JTAG wins first tie
    reset = 1'b1; cyc(); reset = 1'b0;
    jdo = jb(1'b1, 32'h11111111); take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h22222222;
    cyc();
    chk("t3 j issue addr", ram_addr, 8'h00);
    chk("t3 j issue wdata", ram_wdata, 32'h11111111);
    chk("t3 j issue waitreq", avs_waitrequest, 1);
    cyc();
    chk("t3 dead waitreq", avs_waitrequest, 1);
    chk("t3 dead ram_wr", ram_wr, 0);
    cyc();
    chk("t3 a issue addr", ram_addr, 8'h20);
    chk("t3 a issue wdata", ram_wdata, 32'h22222222);
    chk("t3 a issue ram_wr", ram_wr, 1);
    chk("t3 a issue waitreq", avs_waitrequest, 0);
    avs_write = 1'b0;
    cyc();
    chk("t3 idle waitreq", avs_waitrequest, 1);
    jop(1'b1, 32'h33333333, ia, iw);
    chk("t3 solo addr", ia, 8'h01);
    // JTAG was last: Avalon wins this tie
    jdo = jb(1'b1, 32'h44444444); take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    avs_write = 1'b1; avs_address = 8'h21; avs_writedata = 32'h55555555;
    cyc();
    chk("t3 tie2 a addr", ram_addr, 8'h21);
    chk("t3 tie2 a waitreq", avs_waitrequest, 0);
    avs_write = 1'b0;
    cyc();
    cyc();
    chk("t3 tie2 j addr", ram_addr, 8'h02);
    chk("t3 tie2 j wdata", ram_wdata, 32'h44444444);
    chk("t3 tie2 j busy", jtag_busy, 1);
    cyc();
    chk("t3 mem20", mem[8'h20], 32'h22222222);
    chk("t3 mem00", mem[8'h00], 32'h11111111);
    chk("t3 mem21", mem[8'h21], 32'h55555555);

    // Avalon read latency
    avs_write = 1'b1; avs_address = 8'h05; avs_writedata = 32'h12345678;
    cyc();
    chk("t4 wr waitreq", avs_waitrequest, 0);
    avs_write = 1'b0;
    cyc();
    avs_read = 1'b1; avs_address = 8'h05;
    #1;
    chk("t4 t waitreq", avs_waitrequest, 1);
    cyc();
    chk("t4 t+1 waitreq", avs_waitrequest, 1);
    cyc();
    chk("t4 t+2 waitreq", avs_waitrequest, 0);
    chk("t4 t+2 readdata", avs_readdata, 32'h12345678);
    avs_read = 1'b0;
    cyc();
    chk("t4 held readdata", avs_readdata, 32'h12345678);
    chk("t4 idle waitreq", avs_waitrequest, 1);

    // Overrun: second strobe one cycle after the first is dropped
    jtag_a(8'h05);
    jdo = jb(1'b0, 32'h0); take_action_ocimem_b = 1'b1;
    cyc();
    jdo = jb(1'b1, 32'hFFFFFFFF);
    cyc();
    take_action_ocimem_b = 1'b0;
    chk("t5 overrun", jtag_overrun, 1);
    chk("t5 issue addr", ram_addr, 8'h05);
    chk("t5 issue ram_wr", ram_wr, 0);
    cyc(); cyc();
    chk("t5 MonDReg", MonDReg, 32'h12345678);
    chk("t5 busy", jtag_busy, 0);
    cyc(); cyc();
    chk("t5 no reissue", ram_wr, 0);
    chk("t5 overrun sticky", jtag_overrun, 1);
    chk("t5 mem06 untouched", (mem[8'h06] === 32'hFFFFFFFF), 0);

    // Reset during ISSUE of a JTAG write
    jtag_a(8'h30);
    jop(1'b1, 32'hAAAAAAAA, ia, iw);
    jtag_a(8'h30);
    jdo = jb(1'b1, 32'h77777777); take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    cyc();
    chk("t6 issue ram_wr", ram_wr, 1);
    reset = 1'b1;
    #1;
    chk("t6 rstcyc ram_wr", ram_wr, 0);
    chk("t6 rstcyc waitreq", avs_waitrequest, 1);
    cyc();
    chk("t6 MonDReg", MonDReg, 32'h0);
    chk("t6 overrun", jtag_overrun, 0);
    chk("t6 busy", jtag_busy, 0);
    chk("t6 readdata", avs_readdata, 32'h0);
    chk("t6 ram_addr", ram_addr, 8'h00);
    chk("t6 ram_wdata", ram_wdata, 32'h0);
    chk("t6 waitreq", avs_waitrequest, 1);
    reset = 1'b0;
    cyc(); cyc();
    chk("t6 mem30", mem[8'h30], 32'hAAAAAAAA);
    chk("t6 ram_wr idle", ram_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocimem_debug_arbiter.md
Name: ocimem_debug_arbiter

Overview:
Sysclk-domain controller that shares the CPU debug monitor RAM (single-port, 1-cycle read latency) between two requesters. The requesters are the JTAG debug-slave command strobes (ocimem set-address / access, data on jdo) and an Avalon-MM debug slave port. The block sequences each access through a small FSM, arbitrates round-robin, auto-increments the JTAG address pointer and returns JTAG read data on MonDReg.

Parameters:
ADDR_W, 8, monitor RAM word-address width
DATA_W, 32, monitor RAM data width; fixed at 32 for the jdo field mapping

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG debug data from the sysclk debug slave
take_action_ocimem_a  in  1  1-cycle strobe: load JTAG address
take_action_ocimem_b  in  1  1-cycle strobe: JTAG RAM access
MonDReg  out  32  last JTAG read data / write data
jtag_busy  out  1  JTAG access pending or in flight
jtag_overrun  out  1  sticky: access strobe dropped while busy
avs_address  in  ADDR_W  Avalon word address
avs_read  in  1  Avalon read request
avs_write  in  1  Avalon write request
avs_writedata  in  32  Avalon write data
avs_readdata  out  32  Avalon read data
avs_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  monitor RAM address
ram_wr  out  1  monitor RAM write enable
ram_wdata  out  32  monitor RAM write data
ram_rdata  in  32  monitor RAM read data, valid 1 cycle after address

Behaviour:
- Reset values: state IDLE, jtag_addr 0, jtag_pend 0, MonDReg 0, jtag_busy 0, jtag_overrun 0, avs_readdata 0, ram_addr 0, ram_wr 0, ram_wdata 0.
- avs_waitrequest = 1 except in the Avalon completion cycle. It is 1 while in reset.
- take_action_ocimem_a: jtag_addr <= jdo[ADDR_W+16:17]. Applies on the same edge regardless of FSM state.
- take_action_ocimem_b: if jtag_pend=0 and no JTAG op is in flight, latch jtag_pend=1, jtag_dir=jdo[35] (1=write, 0=read) and jtag_wdata=jdo[34:3]. Otherwise the strobe is dropped and jtag_overrun is set to 1. jtag_overrun is cleared only by reset.
- Simultaneous ocimem_a and ocimem_b: the address load applies first, so the access uses the new address.
- jtag_busy = jtag_pend OR (FSM serving JTAG).
- FSM states and transitions:
  - IDLE -> ISSUE when a requester is granted. Requests are jtag_pend and (avs_read|avs_write). avs_write has priority over avs_read if both are asserted.
  - ISSUE: drive ram_addr and ram_wdata, with ram_wr=1 for writes. Op address, data and owner are captured on entry; jtag_pend is cleared on entry for a JTAG grant. A write returns to IDLE; a read goes to CAPTURE.
  - CAPTURE: ram_rdata is valid. For a JTAG owner, MonDReg <= ram_rdata. For an Avalon owner, avs_readdata <= ram_rdata. Returns to IDLE.
- Arbitration: round-robin with a last_grant bit (reset value = Avalon, so JTAG wins the first tie). On a tie the requester not granted last wins. A sole requester always wins.
- JTAG write: MonDReg <= jtag_wdata in ISSUE.
- JTAG auto-increment: jtag_addr <= jtag_addr+1 at op completion (ISSUE for a write, CAPTURE for a read), modulo 2^ADDR_W (wraps to 0 after all-ones). If ocimem_a fires in the same cycle, the load wins and the increment is suppressed.
- Avalon timing:
  - Request held at cycle t while in IDLE with grant: ISSUE at t+1.
  - Write: waitrequest=0 at t+1.
  - Read: waitrequest=0 at t+2, with avs_readdata valid combinationally from ram_rdata in that cycle and registered afterward.
  - The master must hold the request until waitrequest=0. If the request drops mid-op, the op still completes and no re-issue occurs.
- JTAG timing: strobe at edge k -> jtag_pend=1 at k+1 -> ISSUE at k+2 (if the arbiter is free) -> read data on MonDReg from k+4.
- Back-to-back: IDLE is always re-entered between ops, giving one dead cycle. Maximum throughput is 1 write per 2 cycles or 1 read per 3 cycles.
- Reset mid-op: abort immediately. ram_wr is deasserted in the reset cycle, the pending op is discarded, and no partial MonDReg or avs_readdata update occurs.

Test Plan:
- JTAG write then read: ocimem_a with addr 0x10, then ocimem_b write of 0xDEADBEEF, then ocimem_a 0x10 and ocimem_b read -> RAM[0x10]=0xDEADBEEF, MonDReg=0xDEADBEEF, jtag_addr=0x11.
- Auto-increment wrap: set addr 0xFF, then 2 reads -> ram_addr sequence 0xFF then 0x00; jtag_addr ends at 0x01.
- Contention: jtag_pend and avs_write asserted in the same cycle from reset -> JTAG granted first, Avalon write ISSUE follows 2 cycles later. Repeat the tie -> Avalon wins.
- Avalon read latency: RAM[5]=0x12345678, avs_read addr 5 held -> waitrequest low exactly 2 cycles after assertion, readdata=0x12345678.
- Overrun: second ocimem_b one cycle after the first -> first access completes, second is dropped, jtag_overrun=1 until reset.
- Reset during ISSUE of a write -> ram_wr=0 on the next cycle, RAM unchanged after a second reset-free cycle, all outputs at reset values, avs_waitrequest=1.
